seg7_reader: RTL and testbench
==============================

SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 Parameter: NDIG, 4, number of multiplexed digits captured per frame (1..8).
REQ-002 Parameter: STABLE_CYC, 4, consecutive identical cycles required before a digit is captured (1..255).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: seg  input  7  segment lines, active-high; bit0=a, bit1=b, ..., bit6=g.
REQ-006 Port: dig_sel  input  NDIG  digit strobe; one-hot when valid, bit i selects digit i.
REQ-007 Port: clr_ovr  input  1  single-cycle pulse that clears overrun.
REQ-008 Port: out_valid  output  1  a completed frame is presented.
REQ-009 Port: out_ready  input  1  consumer accepts the frame when out_valid is also 1.
REQ-010 Port: bcd_out  output  4*NDIG  decoded nibbles; nibble i maps to bits [4i+3:4i].
REQ-011 Port: dig_err  output  NDIG  bit i set when the pattern captured for digit i was not a legal code.
REQ-012 Port: overrun  output  1  sticky; a completed frame was dropped.

Function
REQ-013 Legal patterns SHALL be 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
REQ-014 An illegal pattern SHALL decode to nibble 0x0 with its dig_err bit set.
REQ-015 A stability counter SHALL increment each cycle that {seg, dig_sel} equals the previous cycle's value and dig_sel is one-hot; any change, or a non-one-hot dig_sel (zero or multiple bits set), SHALL reset it to 0.
REQ-016 When the counter reaches STABLE_CYC-1, the digit SHALL be captured into the internal buffer and its bit set in a captured mask; the same strobe period SHALL NOT capture again until {seg, dig_sel} changes.
REQ-017 Recapturing an already-masked digit before the frame completes SHALL overwrite that digit's buffered value.
REQ-018 The cycle after the mask becomes all ones, the frame SHALL complete: the mask clears and the buffer is offered to the output stage.
REQ-019 Output stage: if out_valid is 0, or out_valid and out_ready are both 1 in the completing cycle, the frame SHALL load into bcd_out/dig_err and out_valid SHALL be 1.
REQ-020 If out_valid is 1 and out_ready is 0 when a frame completes, the new frame SHALL be dropped, the held frame SHALL remain unchanged, and overrun SHALL be set.
REQ-021 bcd_out and dig_err SHALL remain stable while out_valid is 1 and out_ready is 0.
REQ-022 out_valid SHALL drop the cycle after acceptance unless a new frame loads in that same cycle.
REQ-023 clr_ovr SHALL clear overrun; if set and clear coincide, set SHALL win.

Reset
REQ-024 While rst_n is 0: out_valid=0, bcd_out=0, dig_err=0, overrun=0, mask=0, counter=0, previous-sample register=0; this SHALL apply mid-frame and discard any partial frame.

Configuration
REQ-025 With SEG7_READER_HEX_EN defined, the following SHALL additionally be legal: A=0x77, b=0x7C, C=0x39, d=0x5E, E=0x79, F=0x71, decoding to 0xA-0xF.
REQ-026 Without SEG7_READER_HEX_EN, those patterns SHALL be illegal per REQ-014.

Structure
REQ-027 Package seg7_pkg SHALL hold the segment-pattern constants, the seg7_t 7-bit typedef, and the default NDIG/STABLE_CYC values.
REQ-028 Sub-module seg7_reader_decode (combinational, pattern -> {err, nibble}) SHALL be instantiated once, on the sampled pattern.

Verification
REQ-029 NDIG=4, STABLE_CYC=4; strobe digits 0..3 with 0x06, 0x5B, 0x4F, 0x66, each held 6 cycles, out_ready=1 -> one frame, bcd_out=0x4321, dig_err=0.
REQ-030 Digit 2 held for only 3 cycles -> no capture; frame completes only after digit 2 is re-strobed for 4 or more cycles.
REQ-031 Digit 1 shows 0x77 -> without the macro: nibble 1=0, dig_err=0b0010; with the macro: nibble 1=0xA, dig_err=0.
REQ-032 out_ready=0 while two frames complete -> the first frame is held stable, overrun=1; clr_ovr pulse -> overrun=0; out_ready=1 -> the first frame is accepted.
REQ-033 dig_sel=0b0110 for 10 cycles -> no capture; rst_n pulsed low after 2 digits are captured -> all outputs are 0 and the next frame requires all 4 digits.

Source files
------------

// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the seven-segment reader:
//   - seg7_t       : 7-bit segment pattern, bit0=a ... bit6=g, active-high
//   - SEG_*        : segment patterns for digits 0-9 and hex letters A-F
//   - NDIG_DEF     : default number of multiplexed digits per frame
//   - STABLE_CYC_DEF : default number of identical cycles before capture
// -----------------------------------------------------------------------------
package seg7_pkg;

    typedef logic [6:0] seg7_t;

    localparam int NDIG_DEF       = 4;
    localparam int STABLE_CYC_DEF = 4;

    localparam seg7_t SEG_0 = 7'h3F;
    localparam seg7_t SEG_1 = 7'h06;
    localparam seg7_t SEG_2 = 7'h5B;
    localparam seg7_t SEG_3 = 7'h4F;
    localparam seg7_t SEG_4 = 7'h66;
    localparam seg7_t SEG_5 = 7'h6D;
    localparam seg7_t SEG_6 = 7'h7D;
    localparam seg7_t SEG_7 = 7'h07;
    localparam seg7_t SEG_8 = 7'h7F;
    localparam seg7_t SEG_9 = 7'h6F;

    localparam seg7_t SEG_A = 7'h77;
    localparam seg7_t SEG_B = 7'h7C;
    localparam seg7_t SEG_C = 7'h39;
    localparam seg7_t SEG_D = 7'h5E;
    localparam seg7_t SEG_E = 7'h79;
    localparam seg7_t SEG_F = 7'h71;

endpackage : seg7_pkg

// File: rtl/seg7_reader_decode.sv
// -----------------------------------------------------------------------------
// seg7_reader_decode
// Combinational seven-segment pattern to nibble decoder.
// Optional feature macro: SEG7_READER_HEX_EN (hex letters A-F become legal).
// Ports:
//   seg_i  in  7  segment pattern (bit0=a ... bit6=g)
//   nib_o  out 4  decoded value, 0 for an illegal pattern
//   err_o  out 1  pattern is not a legal code
// -----------------------------------------------------------------------------
module seg7_reader_decode
    import seg7_pkg::*;
(
    input  seg7_t      seg_i,
    output logic [3:0] nib_o,
    output logic       err_o
);

    always_comb begin
        nib_o = 4'h0;
        err_o = 1'b0;
        case (seg_i)
            SEG_0:   nib_o = 4'h0;
            SEG_1:   nib_o = 4'h1;
            SEG_2:   nib_o = 4'h2;
            SEG_3:   nib_o = 4'h3;
            SEG_4:   nib_o = 4'h4;
            SEG_5:   nib_o = 4'h5;
            SEG_6:   nib_o = 4'h6;
            SEG_7:   nib_o = 4'h7;
            SEG_8:   nib_o = 4'h8;
            SEG_9:   nib_o = 4'h9;
`ifdef SEG7_READER_HEX_EN
            SEG_A:   nib_o = 4'hA;
            SEG_B:   nib_o = 4'hB;
            SEG_C:   nib_o = 4'hC;
            SEG_D:   nib_o = 4'hD;
            SEG_E:   nib_o = 4'hE;
            SEG_F:   nib_o = 4'hF;
`endif
            default: begin
                nib_o = 4'h0;
                err_o = 1'b1;
            end
        endcase
    end

endmodule : seg7_reader_decode

// File: rtl/seg7_reader.sv
// -----------------------------------------------------------------------------
// seg7_reader
// Captures a multiplexed seven-segment display into a frame of BCD nibbles.
// Each digit must be stable for STABLE_CYC cycles with a one-hot strobe before
// it is captured; once every digit has been captured the frame is offered on a
// valid/ready output stage. Frames arriving while the output is stalled are
// dropped and flagged on the sticky overrun output.
// Optional feature macro: SEG7_READER_HEX_EN (see seg7_reader_decode).
// Ports:
//   clk        in  1       clock, rising edge
//   rst_n      in  1       asynchronous active-low reset
//   seg        in  7       segment lines, active-high
//   dig_sel    in  NDIG    digit strobe, one-hot when valid
//   clr_ovr    in  1       pulse to clear overrun
//   out_valid  out 1       frame presented
//   out_ready  in  1       consumer accepts the frame
//   bcd_out    out 4*NDIG  decoded nibbles, nibble i at [4i+3:4i]
//   dig_err    out NDIG    digit i was an illegal pattern
//   overrun    out 1       sticky, a completed frame was dropped
// -----------------------------------------------------------------------------
module seg7_reader
    import seg7_pkg::*;
#(
    parameter int NDIG       = NDIG_DEF,
    parameter int STABLE_CYC = STABLE_CYC_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        seg,
    input  logic [NDIG-1:0]   dig_sel,
    input  logic              clr_ovr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [4*NDIG-1:0] bcd_out,
    output logic [NDIG-1:0]   dig_err,
    output logic              overrun
);

    localparam int         SW     = 7 + NDIG;
    localparam logic [7:0] CNT_TC = 8'(STABLE_CYC - 1);

    logic [SW-1:0]     prev_q, prev_d;
    logic [7:0]        cnt_q, cnt_d;
    logic              cap_done_q, cap_done_d;
    logic [NDIG-1:0]   mask_q, mask_d;
    logic [4*NDIG-1:0] buf_q, buf_d;
    logic [NDIG-1:0]   err_buf_q, err_buf_d;
    logic              out_valid_q, out_valid_d;
    logic [4*NDIG-1:0] bcd_q, bcd_d;
    logic [NDIG-1:0]   dig_err_q, dig_err_d;
    logic              overrun_q, overrun_d;

    logic [SW-1:0] cur_smp;
    logic          sel_onehot;
    logic          same;
    logic          stable;
    logic          cap_done_eff;
    logic          capture;
    logic          frame_done;
    logic          ovr_set;
    logic [3:0]    dec_nib;
    logic          dec_err;

    assign cur_smp    = {seg, dig_sel};
    assign sel_onehot = (dig_sel != '0) && ((dig_sel & (dig_sel - NDIG'(1))) == '0);
    assign same       = (cur_smp == prev_q);
    assign stable     = sel_onehot && same;
    assign frame_done = &mask_q;

    seg7_reader_decode u_decode (
        .seg_i (seg),
        .nib_o (dec_nib),
        .err_o (dec_err)
    );

    always_comb begin
        prev_d      = cur_smp;
        cnt_d       = '0;
        cap_done_d  = 1'b0;
        capture     = 1'b0;
        mask_d      = mask_q;
        buf_d       = buf_q;
        err_buf_d   = err_buf_q;
        out_valid_d = out_valid_q;
        bcd_d       = bcd_q;
        dig_err_d   = dig_err_q;
        ovr_set     = 1'b0;
        overrun_d   = overrun_q;

        // Counter saturates at the terminal count; cap_done_q then blocks a
        // second capture until the sample changes.
        if (stable) begin
            cnt_d = (cnt_q == CNT_TC) ? cnt_q : cnt_q + 8'd1;
        end
        cap_done_eff = stable && cap_done_q;
        capture      = sel_onehot && (cnt_d == CNT_TC) && !cap_done_eff;
        cap_done_d   = capture || cap_done_eff;

        // A capture in the completing cycle starts the next frame.
        if (frame_done) begin
            mask_d = '0;
        end
        if (capture) begin
            mask_d = mask_d | dig_sel;
            for (int i = 0; i < NDIG; i++) begin
                if (dig_sel[i]) begin
                    buf_d[4*i +: 4] = dec_nib;
                    err_buf_d[i]    = dec_err;
                end
            end
        end

        if (frame_done) begin
            if (!out_valid_q || out_ready) begin
                out_valid_d = 1'b1;
                bcd_d       = buf_q;
                dig_err_d   = err_buf_q;
            end else begin
                ovr_set = 1'b1;
            end
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (ovr_set) begin
            overrun_d = 1'b1;
        end else if (clr_ovr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q      <= '0;
            cnt_q       <= '0;
            cap_done_q  <= 1'b0;
            mask_q      <= '0;
            buf_q       <= '0;
            err_buf_q   <= '0;
            out_valid_q <= 1'b0;
            bcd_q       <= '0;
            dig_err_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            cap_done_q  <= cap_done_d;
            mask_q      <= mask_d;
            buf_q       <= buf_d;
            err_buf_q   <= err_buf_d;
            out_valid_q <= out_valid_d;
            bcd_q       <= bcd_d;
            dig_err_q   <= dig_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_valid = out_valid_q;
    assign bcd_out   = bcd_q;
    assign dig_err   = dig_err_q;
    assign overrun   = overrun_q;

endmodule : seg7_reader

// File: tb/tb_seg7_reader.sv
// -----------------------------------------------------------------------------
// tb_seg7_reader
// Directed testbench for seg7_reader with NDIG=4, STABLE_CYC=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_seg7_reader;

    logic        clk;
    logic        rst_n;
    logic [6:0]  seg;
    logic [3:0]  dig_sel;
    logic        clr_ovr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] bcd_out;
    logic [3:0]  dig_err;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;

    logic [15:0] exp_bcd;
    logic [3:0]  exp_err;

    seg7_reader #(
        .NDIG       (4),
        .STABLE_CYC (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .seg       (seg),
        .dig_sel   (dig_sel),
        .clr_ovr   (clr_ovr),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .bcd_out   (bcd_out),
        .dig_err   (dig_err),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic show(input int d, input logic [6:0] p, input int n);
        dig_sel = 4'(1 << d);
        seg     = p;
        step(n);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        seg       = '0;
        dig_sel   = '0;
        clr_ovr   = 1'b0;
        out_ready = 1'b0;

        // Reset state
        step(2);
        check("rst_valid",   32'(out_valid), 32'd0);
        check("rst_bcd",     32'(bcd_out),   32'h0);
        check("rst_err",     32'(dig_err),   32'h0);
        check("rst_overrun", 32'(overrun),   32'd0);
        rst_n = 1'b1;

        // Basic frame 1,2,3,4 with consumer ready
        out_ready = 1'b1;
        show(0, 7'h06, 6);
        show(1, 7'h5B, 6);
        show(2, 7'h4F, 6);
        check("t1_partial_valid", 32'(out_valid), 32'd0);
        show(3, 7'h66, 4);
        check("t1_full_not_yet", 32'(out_valid), 32'd0);
        step(1);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_bcd",   32'(bcd_out),   32'h4321);
        check("t1_err",   32'(dig_err),   32'h0);
        step(1);
        check("t1_accept_drop", 32'(out_valid), 32'd0);

        // Digit 2 strobed too briefly, then re-strobed long enough
        show(0, 7'h3F, 6);
        show(1, 7'h6D, 6);
        show(2, 7'h7F, 3);
        show(3, 7'h6F, 6);
        check("t2_short_nocap", 32'(out_valid), 32'd0);
        show(2, 7'h7F, 4);
        check("t2_full_not_yet", 32'(out_valid), 32'd0);
        step(1);
        check("t2_valid", 32'(out_valid), 32'd1);
        check("t2_bcd",   32'(bcd_out),   32'h9850);
        step(1);
        check("t2_accept_drop", 32'(out_valid), 32'd0);

        // Hex pattern on digit 1, and a recapture overwriting digit 0
        show(0, 7'h5B, 6);
        show(0, 7'h06, 6);
        show(1, 7'h77, 6);
        show(2, 7'h4F, 6);
        show(3, 7'h66, 4);
        step(1);
`ifdef SEG7_READER_HEX_EN
        exp_bcd = 16'h43A1;
        exp_err = 4'b0000;
`else
        exp_bcd = 16'h4301;
        exp_err = 4'b0010;
`endif
        check("t3_valid", 32'(out_valid), 32'd1);
        check("t3_bcd",   32'(bcd_out),   32'(exp_bcd));
        check("t3_err",   32'(dig_err),   32'(exp_err));
        step(1);

        // Stalled consumer: second frame dropped, overrun set then cleared
        out_ready = 1'b0;
        show(0, 7'h07, 6);
        show(1, 7'h7D, 6);
        show(2, 7'h6F, 6);
        show(3, 7'h3F, 4);
        step(1);
        check("t4_valid", 32'(out_valid), 32'd1);
        check("t4_bcd",   32'(bcd_out),   32'h0967);
        check("t4_no_ovr", 32'(overrun),  32'd0);
        show(0, 7'h5B, 6);
        show(1, 7'h5B, 6);
        show(2, 7'h5B, 6);
        show(3, 7'h5B, 4);
        step(1);
        check("t4_held_valid", 32'(out_valid), 32'd1);
        check("t4_held_bcd",   32'(bcd_out),   32'h0967);
        check("t4_overrun",    32'(overrun),   32'd1);
        clr_ovr = 1'b1;
        step(1);
        clr_ovr = 1'b0;
        check("t4_ovr_clr",    32'(overrun),   32'd0);
        check("t4_still_bcd",  32'(bcd_out),   32'h0967);
        out_ready = 1'b1;
        step(1);
        check("t4_accepted",   32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Non-one-hot strobe, then reset mid-frame
        dig_sel = 4'b0110;
        seg     = 7'h06;
        step(10);
        show(0, 7'h06, 6);
        show(3, 7'h66, 6);
        check("t5_multi_nocap", 32'(out_valid), 32'd0);
        rst_n = 1'b0;
        #1;
        check("t5_rst_valid",   32'(out_valid), 32'd0);
        check("t5_rst_bcd",     32'(bcd_out),   32'h0);
        check("t5_rst_err",     32'(dig_err),   32'h0);
        check("t5_rst_overrun", 32'(overrun),   32'd0);
        step(2);
        rst_n = 1'b1;
        show(2, 7'h4F, 6);
        show(3, 7'h66, 6);
        check("t5_partial_discarded", 32'(out_valid), 32'd0);
        show(0, 7'h7F, 6);
        show(1, 7'h07, 4);
        step(1);
        check("t5_valid", 32'(out_valid), 32'd1);
        check("t5_bcd",   32'(bcd_out),   32'h4378);
        check("t5_err",   32'(dig_err),   32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_seg7_reader
